// File: rtl/score_controller.sv
// rtl/score_controller.sv - baseball scoreboard: count, score, inning and game-end control
module score_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       ball,
  input  logic       strike,
  input  logic       single,
  input  logic       double,
  input  logic       triple,
  input  logic       homerun,
  input  logic       runner_1st,
  input  logic       runner_2nd,
  input  logic       runner_3rd,
  output logic [1:0] ball_cnt,
  output logic [1:0] strike_cnt,
  output logic [1:0] out_cnt,
  output logic       ball_count_3,
  output logic [7:0] score_away,
  output logic [7:0] score_home,
  output logic [3:0] inning,
  output logic       bottom,
  output logic       clear_bases,
  output logic       game_over
);

  typedef enum logic [1:0] {PLAY, CHANGE, OVER} state_t;

  state_t     state_q;
  logic [1:0] ball_q, strike_q, out_q;
  logic       ball_count_3_q;
  logic [7:0] away_q, home_q;
  logic [3:0] inning_q;
  logic       bottom_q;
  logic       clear_bases_q;
  logic       game_over_q;

  logic       ev_ball, ev_strike, ev_single, ev_double, ev_triple, ev_homerun, ev_hit;
  logic [2:0] runs;
  logic [8:0] bat_sum;
  logic [7:0] bat_new, away_d, home_d;
  logic [1:0] ball_d, strike_d;
  logic       walk_off, game_ends;

  // Fixed-priority pick of one play event; lower-priority pulses are dropped
  always_comb begin
    ev_ball    = ball;
    ev_strike  = strike & ~ball;
    ev_single  = single & ~ball & ~strike;
    ev_double  = double & ~(ball | strike | single);
    ev_triple  = triple & ~(ball | strike | single | double);
    ev_homerun = homerun & ~(ball | strike | single | double | triple);
    ev_hit     = ev_single | ev_double | ev_triple | ev_homerun;
  end

  // Runs forced home by the chosen event, saturating score for the batting team
  always_comb begin
    runs = 3'd0;
    if (ev_ball && ball_q == 2'd3) begin
      runs = {2'b00, runner_1st & runner_2nd & runner_3rd};
    end else if (ev_single) begin
      runs = {2'b00, runner_3rd};
    end else if (ev_double) begin
      runs = {2'b00, runner_2nd} + {2'b00, runner_3rd};
    end else if (ev_triple) begin
      runs = {2'b00, runner_1st} + {2'b00, runner_2nd} + {2'b00, runner_3rd};
    end else if (ev_homerun) begin
      runs = 3'd1 + {2'b00, runner_1st} + {2'b00, runner_2nd} + {2'b00, runner_3rd};
    end
    bat_sum  = {1'b0, (bottom_q ? home_q : away_q)} + {6'b000000, runs};
    bat_new  = bat_sum[8] ? 8'hFF : bat_sum[7:0];
    away_d   = bottom_q ? away_q : bat_new;
    home_d   = bottom_q ? bat_new : home_q;
    walk_off = bottom_q && (inning_q >= 4'd9) && (runs != 3'd0) && (home_d > away_d);
  end

  // End-of-half decision made while sitting in CHANGE
  always_comb begin
    game_ends = (!bottom_q && inning_q >= 4'd9 && home_q > away_q) ||
                ( bottom_q && inning_q >= 4'd9 && home_q != away_q) ||
                ( bottom_q && inning_q == 4'd15);
  end

  // Next ball/strike count for an event accepted in PLAY
  always_comb begin
    ball_d   = ball_q;
    strike_d = strike_q;
    if (ev_ball) begin
      if (ball_q == 2'd3) begin
        ball_d   = 2'd0;
        strike_d = 2'd0;
      end else begin
        ball_d = ball_q + 2'd1;
      end
    end else if (ev_strike) begin
      if (strike_q == 2'd2) begin
        ball_d   = 2'd0;
        strike_d = 2'd0;
      end else begin
        strike_d = strike_q + 2'd1;
      end
    end else if (ev_hit) begin
      ball_d   = 2'd0;
      strike_d = 2'd0;
    end
  end

  // Game FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= PLAY;
      ball_q         <= 2'd0;
      strike_q       <= 2'd0;
      out_q          <= 2'd0;
      ball_count_3_q <= 1'b0;
      away_q         <= 8'd0;
      home_q         <= 8'd0;
      inning_q       <= 4'd1;
      bottom_q       <= 1'b0;
      clear_bases_q  <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      case (state_q)
        PLAY: begin
          clear_bases_q  <= 1'b0;
          ball_q         <= ball_d;
          ball_count_3_q <= (ball_d == 2'd3);
          strike_q       <= strike_d;
          away_q         <= away_d;
          home_q         <= home_d;
          if (ev_strike && strike_q == 2'd2) begin
            if (out_q == 2'd2) begin
              out_q         <= 2'd0;
              clear_bases_q <= 1'b1;
              state_q       <= CHANGE;
            end else begin
              out_q <= out_q + 2'd1;
            end
          end
          if (walk_off) begin
            state_q     <= OVER;
            game_over_q <= 1'b1;
          end
        end
        CHANGE: begin
          clear_bases_q <= 1'b0;
          if (game_ends) begin
            state_q     <= OVER;
            game_over_q <= 1'b1;
          end else begin
            bottom_q <= ~bottom_q;
            if (bottom_q) begin
              inning_q <= inning_q + 4'd1;
            end
            state_q <= PLAY;
          end
        end
        default: begin
          clear_bases_q <= 1'b0;
        end
      endcase
    end
  end

  assign ball_cnt     = ball_q;
  assign strike_cnt   = strike_q;
  assign out_cnt      = out_q;
  assign ball_count_3 = ball_count_3_q;
  assign score_away   = away_q;
  assign score_home   = home_q;
  assign inning       = inning_q;
  assign bottom       = bottom_q;
  assign clear_bases  = clear_bases_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_score_controller.sv
// tb/tb_score_controller.sv - table, directed and random checks of score_controller
module tb_score_controller;

  localparam bit [5:0] EB = 6'd1, ES = 6'd2, E1 = 6'd4, E2 = 6'd8, E3 = 6'd16, EH = 6'd32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ball = 1'b0, strike = 1'b0, single = 1'b0, double = 1'b0, triple = 1'b0, homerun = 1'b0;
  logic       runner_1st = 1'b0, runner_2nd = 1'b0, runner_3rd = 1'b0;
  logic [1:0] ball_cnt, strike_cnt, out_cnt;
  logic       ball_count_3;
  logic [7:0] score_away, score_home;
  logic [3:0] inning;
  logic       bottom, clear_bases, game_over;

  int tests = 0;
  int fails = 0;

  // behavioural model state; phase 0 = play, 1 = between halves, 2 = final
  int m_balls, m_strikes, m_outs, m_away, m_home, m_inning, m_bottom, m_clear, m_phase;

  typedef struct {
    bit       rst;
    bit [5:0] ev;
    bit [2:0] rn;
    int       b, s, o, a, h, inn, bot, clr, go;
  } vec_t;
  vec_t vecs[$];

  score_controller dut (
    .clk(clk), .reset(reset),
    .ball(ball), .strike(strike), .single(single), .double(double), .triple(triple), .homerun(homerun),
    .runner_1st(runner_1st), .runner_2nd(runner_2nd), .runner_3rd(runner_3rd),
    .ball_cnt(ball_cnt), .strike_cnt(strike_cnt), .out_cnt(out_cnt), .ball_count_3(ball_count_3),
    .score_away(score_away), .score_home(score_home), .inning(inning), .bottom(bottom),
    .clear_bases(clear_bases), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit [5:0] ev, input bit [2:0] rn);
    int runs, r1, r2, r3;
    r1 = rn[0]; r2 = rn[1]; r3 = rn[2];
    m_clear = 0;
    if (rst) begin
      m_balls = 0; m_strikes = 0; m_outs = 0; m_away = 0; m_home = 0;
      m_inning = 1; m_bottom = 0; m_phase = 0;
    end else if (m_phase == 1) begin
      if ((!m_bottom && m_inning >= 9 && m_home > m_away) ||
          (m_bottom && m_inning >= 9 && m_home != m_away) ||
          (m_bottom && m_inning == 15)) begin
        m_phase = 2;
      end else begin
        if (m_bottom) m_inning++;
        m_bottom = !m_bottom;
        m_phase = 0;
      end
    end else if (m_phase == 0) begin
      runs = 0;
      if (ev[0]) begin
        if (m_balls == 3) begin
          m_balls = 0; m_strikes = 0; runs = r1 * r2 * r3;
        end else m_balls++;
      end else if (ev[1]) begin
        if (m_strikes == 2) begin
          m_balls = 0; m_strikes = 0; m_outs++;
          if (m_outs == 3) begin
            m_outs = 0; m_clear = 1; m_phase = 1;
          end
        end else m_strikes++;
      end else if (ev[5:2] != 0) begin
        m_balls = 0; m_strikes = 0;
        if (ev[2]) runs = r3;
        else if (ev[3]) runs = r2 + r3;
        else if (ev[4]) runs = r1 + r2 + r3;
        else runs = 1 + r1 + r2 + r3;
      end
      if (m_bottom) m_home = (m_home + runs > 255) ? 255 : m_home + runs;
      else m_away = (m_away + runs > 255) ? 255 : m_away + runs;
      if (m_bottom && m_inning >= 9 && m_home > m_away) m_phase = 2;
    end
  endtask

  // one clock: drive, step the model, compare every output against it
  task automatic cycle(input bit rst, input bit [5:0] ev, input bit [2:0] rn);
    logic [29:0] act, exp;
    reset = rst;
    {homerun, triple, double, single, strike, ball} = ev;
    {runner_3rd, runner_2nd, runner_1st} = rn;
    @(posedge clk);
    #1;
    model_step(rst, ev, rn);
    act = {ball_cnt, strike_cnt, out_cnt, ball_count_3, score_away, score_home, inning, bottom, clear_bases, game_over};
    exp = {2'(m_balls), 2'(m_strikes), 2'(m_outs), (m_balls == 3), 8'(m_away), 8'(m_home),
           4'(m_inning), 1'(m_bottom), 1'(m_clear), (m_phase == 2)};
    check("model", {2'b00, act}, {2'b00, exp});
  endtask

  task automatic three_outs();
    repeat (9) cycle(0, ES, 3'b000);
    cycle(0, 6'd0, 3'b000);
  endtask

  task automatic add(input bit rst, input bit [5:0] ev, input bit [2:0] rn,
                     input int b, input int s, input int o, input int a, input int h,
                     input int inn, input int bot, input int clr, input int go);
    vec_t v;
    v.rst = rst; v.ev = ev; v.rn = rn;
    v.b = b; v.s = s; v.o = o; v.a = a; v.h = h; v.inn = inn; v.bot = bot; v.clr = clr; v.go = go;
    vecs.push_back(v);
  endtask

  task automatic random_cycle();
    int w;
    bit [5:0] ev;
    bit rst;
    w = $urandom_range(0, 99);
    if (w < 35) ev = 6'd0;
    else if (w < 52) ev = EB;
    else if (w < 77) ev = ES;
    else if (w < 85) ev = E1;
    else if (w < 90) ev = E2;
    else if (w < 93) ev = E3;
    else ev = EH;
    if ($urandom_range(0, 9) == 0) ev = ev | 6'($urandom);
    rst = ($urandom_range(0, 2999) == 0) || (m_phase == 2 && $urandom_range(0, 19) == 0);
    cycle(rst, ev, 3'($urandom));
  endtask

  initial begin
    // rst ev rn | b s o away home inn bot clr go
    add(1, EB,      3'b111, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, EB,      3'b111, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, EB,      3'b111, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, EB,      3'b111, 3, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, EB,      3'b111, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(0, EB | E1, 3'b111, 1, 0, 0, 1, 0, 1, 0, 0, 0);
    add(0, ES,      3'b000, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    add(0, E1,      3'b100, 0, 0, 0, 2, 0, 1, 0, 0, 0);
    add(0, EH,      3'b111, 0, 0, 0, 6, 0, 1, 0, 0, 0);
    add(0, E3,      3'b001, 0, 0, 0, 7, 0, 1, 0, 0, 0);
    add(0, ES | E2, 3'b111, 0, 1, 0, 7, 0, 1, 0, 0, 0);
    add(0, ES,      3'b000, 0, 2, 0, 7, 0, 1, 0, 0, 0);
    add(0, ES,      3'b000, 0, 0, 1, 7, 0, 1, 0, 0, 0);
    add(0, ES,      3'b000, 0, 1, 1, 7, 0, 1, 0, 0, 0);
    add(0, ES,      3'b000, 0, 2, 1, 7, 0, 1, 0, 0, 0);
    add(0, ES,      3'b000, 0, 0, 2, 7, 0, 1, 0, 0, 0);
    add(0, ES,      3'b000, 0, 1, 2, 7, 0, 1, 0, 0, 0);
    add(0, ES,      3'b000, 0, 2, 2, 7, 0, 1, 0, 0, 0);
    add(0, ES,      3'b000, 0, 0, 0, 7, 0, 1, 0, 1, 0);
    add(0, EB,      3'b111, 0, 0, 0, 7, 0, 1, 1, 0, 0);
    add(0, E2,      3'b110, 0, 0, 0, 7, 2, 1, 1, 0, 0);
    add(0, EB,      3'b000, 1, 0, 0, 7, 2, 1, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].ev, vecs[i].rn);
      check($sformatf("row%0d.ball", i),   ball_cnt,     vecs[i].b);
      check($sformatf("row%0d.strike", i), strike_cnt,   vecs[i].s);
      check($sformatf("row%0d.out", i),    out_cnt,      vecs[i].o);
      check($sformatf("row%0d.b3", i),     ball_count_3, (vecs[i].b == 3));
      check($sformatf("row%0d.away", i),   score_away,   vecs[i].a);
      check($sformatf("row%0d.home", i),   score_home,   vecs[i].h);
      check($sformatf("row%0d.inning", i), inning,       vecs[i].inn);
      check($sformatf("row%0d.bottom", i), bottom,       vecs[i].bot);
      check($sformatf("row%0d.clear", i),  clear_bases,  vecs[i].clr);
      check($sformatf("row%0d.over", i),   game_over,    vecs[i].go);
    end

    // home score saturates at 255
    cycle(1, 6'd0, 3'b000);
    three_outs();
    repeat (63) cycle(0, EH, 3'b111);
    cycle(0, E1, 3'b100);
    check("sat.pre", score_home, 253);
    cycle(0, EH, 3'b111);
    check("sat.home", score_home, 255);
    check("sat.over", game_over, 0);

    // walk-off double in the bottom of the 9th, then the game holds
    cycle(1, 6'd0, 3'b000);
    cycle(0, EH, 3'b011);
    three_outs();
    cycle(0, EH, 3'b001);
    three_outs();
    repeat (7) begin
      three_outs();
      three_outs();
    end
    check("wo.inning", inning, 9);
    three_outs();
    check("wo.bottom", bottom, 1);
    check("wo.away", score_away, 3);
    check("wo.home_pre", score_home, 2);
    check("wo.over_pre", game_over, 0);
    cycle(0, E2, 3'b110);
    check("wo.home", score_home, 4);
    check("wo.over", game_over, 1);
    check("wo.clear", clear_bases, 0);
    cycle(0, EH, 3'b111);
    repeat (3) cycle(0, ES, 3'b000);
    check("wo.hold_home", score_home, 4);
    check("wo.hold_strike", strike_cnt, 0);
    check("wo.hold_over", game_over, 1);

    // tied through the bottom of the 15th ends the game
    cycle(1, 6'd0, 3'b000);
    repeat (29) three_outs();
    check("t15.inning", inning, 15);
    check("t15.bottom", bottom, 1);
    repeat (9) cycle(0, ES, 3'b000);
    check("t15.clear", clear_bases, 1);
    cycle(0, 6'd0, 3'b000);
    check("t15.over", game_over, 1);
    check("t15.inning_hold", inning, 15);
    check("t15.bottom_hold", bottom, 1);

    // reset while changing halves, with an event pulsed alongside
    cycle(1, 6'd0, 3'b000);
    repeat (9) cycle(0, ES, 3'b000);
    check("rc.clear_pre", clear_bases, 1);
    cycle(1, ES, 3'b111);
    check("rc.clear", clear_bases, 0);
    check("rc.bottom", bottom, 0);
    check("rc.inning", inning, 1);
    check("rc.strike", strike_cnt, 0);
    check("rc.out", out_cnt, 0);
    check("rc.over", game_over, 0);

    cycle(1, 6'd0, 3'b000);
    for (int i = 0; i < 20000; i++) random_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/score_controller.md
SCORE_CONTROLLER -- requirements
Module: score_controller

Interface
REQ-001 The block SHALL have clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have ball, strike, single, double, triple and homerun, each an input, 1 bit: one-cycle play-event pulses.
REQ-004 The block SHALL have runner_1st, runner_2nd and runner_3rd, each an input, 1 bit: base occupancy before the current event, driven by the runner board.
REQ-005 The block SHALL have ball_cnt, output, 2 bits: balls in the current at-bat.
REQ-006 The block SHALL have strike_cnt, output, 2 bits: strikes in the current at-bat.
REQ-007 The block SHALL have out_cnt, output, 2 bits: outs in the current half-inning.
REQ-008 The block SHALL have ball_count_3, output, 1 bit: high exactly when ball_cnt == 3; feeds the runner board.
REQ-009 The block SHALL have score_away and score_home, each an output, 8 bits: team scores.
REQ-010 The block SHALL have inning, output, 4 bits: current inning, range 1..15.
REQ-011 The block SHALL have bottom, output, 1 bit: 0 = top half (away bats), 1 = bottom half (home bats).
REQ-012 The block SHALL have clear_bases, output, 1 bit: one-cycle pulse that tells the runner board to empty all bases.
REQ-013 The block SHALL have game_over, output, 1 bit: high once the game is final.

Function
REQ-014 All outputs SHALL be registered; the response to an event sampled at edge N SHALL be visible after edge N.
REQ-015 Simultaneous event pulses SHALL be resolved by fixed priority ball > strike > single > double > triple > homerun; lower-priority pulses in that cycle SHALL be dropped.
REQ-016 The FSM SHALL have the states PLAY, CHANGE and OVER; events SHALL be accepted only in PLAY.
REQ-017 Ball with ball_cnt < 3: ball_cnt increments.
REQ-018 Ball with ball_cnt == 3 (walk): ball_cnt and strike_cnt clear; runs scored = 1 if all three runner inputs are 1, else 0.
REQ-019 Strike with strike_cnt < 2: strike_cnt increments.
REQ-020 Strike with strike_cnt == 2 (strikeout): both counts clear and out_cnt increments.
REQ-021 Third out (out_cnt == 2 at a strikeout): out_cnt clears, clear_bases pulses, and the FSM enters CHANGE.
REQ-022 Any hit SHALL clear ball_cnt and strike_cnt.
REQ-023 Runs scored per hit SHALL be: single = r3; double = r2+r3; triple = r1+r2+r3; homerun = 1+r1+r2+r3, giving 0..4 runs.
REQ-024 Runs SHALL be added to score_away when bottom == 0, else to score_home.
REQ-025 Score addition SHALL saturate at 255.
REQ-026 CHANGE SHALL last exactly one cycle, during which all events are ignored; on exit it SHALL either finish the game or switch halves.
REQ-027 From CHANGE, go to OVER (game ends, halves not switched) when any of these holds:
  - the top half of inning >= 9 ended and score_home > score_away;
  - the bottom half of inning >= 9 ended and the scores differ;
  - the bottom half of inning 15 ended (any score).
REQ-028 Otherwise CHANGE SHALL toggle bottom; on a bottom-to-top switch, inning increments; the FSM then returns to PLAY.
REQ-029 Walk-off: in PLAY with bottom == 1 and inning >= 9, if an event makes score_home > score_away, the FSM SHALL enter OVER directly after that edge, with no CHANGE and no clear_bases.
REQ-030 In OVER, all counters and scores SHALL hold and events SHALL be ignored until reset.
REQ-031 game_over SHALL be 1 exactly in OVER.
REQ-032 clear_bases SHALL be 0 except the single cycle after a third out.

Reset
REQ-033 With reset high at an edge, the next state SHALL be:
  - ball_cnt = strike_cnt = out_cnt = 0;
  - score_away = score_home = 0;
  - inning = 1, bottom = 0;
  - clear_bases = 0, game_over = 0, ball_count_3 = 0;
  - FSM = PLAY.
REQ-034 Reset SHALL override every event in the same cycle.
REQ-035 Reset asserted in CHANGE or OVER SHALL return the block to the REQ-033 state.

Verification
REQ-036 Four ball pulses with bases loaded, top of inning 1 -> ball_cnt goes 1, 2, 3 (ball_count_3 = 1), then 0; score_away = 1.
REQ-037 Nine strike pulses, top of inning 1 -> out_cnt goes 1, 2; on the 9th strike, clear_bases pulses for one cycle; one cycle later bottom = 1 and inning = 1.
REQ-038 Homerun with r1 = r2 = r3 = 1 and score_home = 253 in the bottom half -> score_home = 255 (saturated).
REQ-039 Bottom of inning 9, away 3, home 2, double with r2 = r3 = 1 -> score_home = 4 and game_over = 1 next cycle; later events change nothing.
REQ-040 ball and single pulsed in the same cycle with ball_cnt = 0 -> ball_cnt = 1, no runs scored, strike_cnt unchanged.
REQ-041 Reset during CHANGE -> next cycle shows the full REQ-033 state, with clear_bases = 0.
